axi_slave_decerr: RTL and testbench
===================================

Name: axi_slave_decerr

Overview:
Parametrised error-responding AXI slave. It replaces the tie-off default slave on unused interconnect ports and in unmapped address windows. It completes every write and read burst with a programmable error response, so masters never hang. It also keeps error statistics that a debug register block can read.

Parameters:
ID_WIDTH, 4, width of all ID fields
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width; STRB width = DATA_WIDTH/8
RESP_CODE, 2'b11, response driven on B and R (2'b10 = SLVERR, 2'b11 = DECERR)
RD_FILL_DATA, {DATA_WIDTH{1'b0}}, constant driven on SLAVE_RD_DATA
CNT_WIDTH, 16, width of the error counters

Ports:
clk  in  1  sole clock
rst  in  1  synchronous, active-high reset
SLAVE_CLK  out  1  = clk
SLAVE_RSTN  out  1  = ~rst
SLAVE_WR_ADDR_ID  in  ID_WIDTH  AW ID
SLAVE_WR_ADDR  in  ADDR_WIDTH  AW address
SLAVE_WR_ADDR_LEN  in  8  beats-1
SLAVE_WR_ADDR_BURST  in  2  ignored
SLAVE_WR_ADDR_VALID  in  1  AW valid
SLAVE_WR_ADDR_READY  out  1  AW ready
SLAVE_WR_DATA  in  DATA_WIDTH  ignored
SLAVE_WR_STRB  in  DATA_WIDTH/8  ignored
SLAVE_WR_DATA_LAST  in  1  W last
SLAVE_WR_DATA_VALID  in  1  W valid
SLAVE_WR_DATA_READY  out  1  W ready
SLAVE_WR_BACK_ID  out  ID_WIDTH  B ID
SLAVE_WR_BACK_RESP  out  2  B response
SLAVE_WR_BACK_VALID  out  1  B valid
SLAVE_WR_BACK_READY  in  1  B ready
SLAVE_RD_ADDR_ID  in  ID_WIDTH  AR ID
SLAVE_RD_ADDR  in  ADDR_WIDTH  AR address
SLAVE_RD_ADDR_LEN  in  8  beats-1
SLAVE_RD_ADDR_BURST  in  2  ignored
SLAVE_RD_ADDR_VALID  in  1  AR valid
SLAVE_RD_ADDR_READY  out  1  AR ready
SLAVE_RD_BACK_ID  out  ID_WIDTH  R ID
SLAVE_RD_DATA  out  DATA_WIDTH  R data
SLAVE_RD_DATA_RESP  out  2  R response
SLAVE_RD_DATA_LAST  out  1  R last
SLAVE_RD_DATA_VALID  out  1  R valid
SLAVE_RD_DATA_READY  in  1  R ready
err_wr_cnt  out  CNT_WIDTH  saturating count of accepted AW
err_rd_cnt  out  CNT_WIDTH  saturating count of accepted AR
last_err_addr  out  ADDR_WIDTH  address of the most recent accepted AW/AR
err_pulse  out  1  one-cycle pulse per accepted AW or AR

Behaviour:
- All outputs are registered. While rst=1, every output is 0 except SLAVE_CLK and SLAVE_RSTN. Both ADDR_READYs assert at the first edge after rst falls.
- Write FSM has three states, each accepting one burst at a time:
  - W_IDLE: AW_READY=1. An AW handshake at edge T latches ID and LEN, clears the beat counter, sets AW_READY=0 and W_READY=1 at T+1, and moves to W_DATA.
  - W_DATA: each W handshake increments the beat counter. The burst ends on the first beat where WLAST=1 or counter==LEN, whichever comes first; this guards against a missing WLAST. At the ending edge: W_READY=0, B_VALID=1, B_ID=latched ID, B_RESP=RESP_CODE, and the FSM moves to W_RESP.
  - W_RESP: hold B outputs until BREADY. At the handshake: B_VALID=0, AW_READY=1, back to W_IDLE.
- W beats presented before AW are stalled, because W_READY=0 in W_IDLE.
- Read FSM has two states:
  - R_IDLE: AR_READY=1. An AR handshake at T latches ID and LEN and sets AR_READY=0 at T+1. R_VALID=1 with RDATA=RD_FILL_DATA, RRESP=RESP_CODE, RID=latched ID. RLAST=(LEN==0). The FSM moves to R_DATA.
  - R_DATA: each R handshake advances the beat counter. RLAST=1 exactly on beat LEN. Total beats = LEN+1 (1..256). At the RLAST handshake: R_VALID=0, RLAST=0, AR_READY=1, back to R_IDLE.
- R_VALID stays high between beats; no bubbles while RREADY=1.
- Latency from address handshake to first R beat is 1 cycle. Turnaround from a B or last-R handshake to ADDR_READY is 1 cycle.
- Read and write FSMs are fully independent; simultaneous AW and AR are both accepted in the same cycle.
- Statistics:
  - Counters increment at the address handshake and saturate at all-ones.
  - last_err_addr updates on an address handshake. If AW and AR are accepted in the same cycle, the write address wins.
  - err_pulse is high the cycle after any address handshake.
- Reset mid-burst: rst=1 aborts both FSMs at that edge. No pending response is issued afterward; counters and last_err_addr clear.

Test Plan:
- Single write: AW ID=4'h5, LEN=0; one W beat with WLAST; BREADY=1 -> BVALID 1 cycle after WLAST, BID=5, BRESP=2'b11; AW_READY high again next cycle; err_wr_cnt=1.
- Read burst: AR ID=4'hA, LEN=3, addr 32'h4000_0000; RREADY toggled 1,0,1,1,1 -> exactly 4 beats, RDATA=0, RRESP=2'b11, RID=A, RLAST only on beat 4; last_err_addr=32'h4000_0000.
- Missing WLAST: AW LEN=2, three W beats with WLAST=0 -> burst ends on beat 3; B issued; a fourth W beat is stalled (W_READY=0).
- Simultaneous AW (addr 0x100) and AR (addr 0x200) in the same cycle -> both accepted; err_wr_cnt=err_rd_cnt=1; last_err_addr=0x100; B and R complete independently.
- Reset during an R burst at beat 2 of LEN=7 -> R_VALID=0 the edge after rst; counters=0; after release AR_READY=1, and a new LEN=0 read completes with RLAST.
- Saturation with CNT_WIDTH=2: five writes -> err_wr_cnt stays at 3.

Source files
------------

// File: rtl/axi_slave_decerr.sv
// rtl/axi_slave_decerr.sv - error-responding AXI default slave with error statistics
// Completes every AW/W/B and AR/R burst with RESP_CODE; independent write and read FSMs.
module axi_slave_decerr #(
   parameter int                    ID_WIDTH     = 4,
   parameter int                    ADDR_WIDTH   = 32,
   parameter int                    DATA_WIDTH   = 32,
   parameter logic [1:0]            RESP_CODE    = 2'b11,
   parameter logic [DATA_WIDTH-1:0] RD_FILL_DATA = '0,
   parameter int                    CNT_WIDTH    = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   output logic                    SLAVE_CLK,
   output logic                    SLAVE_RSTN,
   input  logic [ID_WIDTH-1:0]     SLAVE_WR_ADDR_ID,
   input  logic [ADDR_WIDTH-1:0]   SLAVE_WR_ADDR,
   input  logic [7:0]              SLAVE_WR_ADDR_LEN,
   input  logic [1:0]              SLAVE_WR_ADDR_BURST,
   input  logic                    SLAVE_WR_ADDR_VALID,
   output logic                    SLAVE_WR_ADDR_READY,
   input  logic [DATA_WIDTH-1:0]   SLAVE_WR_DATA,
   input  logic [DATA_WIDTH/8-1:0] SLAVE_WR_STRB,
   input  logic                    SLAVE_WR_DATA_LAST,
   input  logic                    SLAVE_WR_DATA_VALID,
   output logic                    SLAVE_WR_DATA_READY,
   output logic [ID_WIDTH-1:0]     SLAVE_WR_BACK_ID,
   output logic [1:0]              SLAVE_WR_BACK_RESP,
   output logic                    SLAVE_WR_BACK_VALID,
   input  logic                    SLAVE_WR_BACK_READY,
   input  logic [ID_WIDTH-1:0]     SLAVE_RD_ADDR_ID,
   input  logic [ADDR_WIDTH-1:0]   SLAVE_RD_ADDR,
   input  logic [7:0]              SLAVE_RD_ADDR_LEN,
   input  logic [1:0]              SLAVE_RD_ADDR_BURST,
   input  logic                    SLAVE_RD_ADDR_VALID,
   output logic                    SLAVE_RD_ADDR_READY,
   output logic [ID_WIDTH-1:0]     SLAVE_RD_BACK_ID,
   output logic [DATA_WIDTH-1:0]   SLAVE_RD_DATA,
   output logic [1:0]              SLAVE_RD_DATA_RESP,
   output logic                    SLAVE_RD_DATA_LAST,
   output logic                    SLAVE_RD_DATA_VALID,
   input  logic                    SLAVE_RD_DATA_READY,
   output logic [CNT_WIDTH-1:0]    err_wr_cnt,
   output logic [CNT_WIDTH-1:0]    err_rd_cnt,
   output logic [ADDR_WIDTH-1:0]   last_err_addr,
   output logic                    err_pulse
);

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
   typedef enum logic       {R_IDLE, R_DATA}         rd_state_t;

   wr_state_t             wr_state_q, wr_state_d;
   logic                  aw_ready_q, aw_ready_d;
   logic                  w_ready_q, w_ready_d;
   logic                  b_valid_q, b_valid_d;
   logic [1:0]            b_resp_q, b_resp_d;
   logic [ID_WIDTH-1:0]   b_id_q, b_id_d;
   logic [ID_WIDTH-1:0]   wr_id_q, wr_id_d;
   logic [7:0]            wr_len_q, wr_len_d;
   logic [7:0]            wr_beat_q, wr_beat_d;

   rd_state_t             rd_state_q, rd_state_d;
   logic                  ar_ready_q, ar_ready_d;
   logic                  r_valid_q, r_valid_d;
   logic                  r_last_q, r_last_d;
   logic [1:0]            r_resp_q, r_resp_d;
   logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
   logic [ID_WIDTH-1:0]   r_id_q, r_id_d;
   logic [7:0]            rd_len_q, rd_len_d;
   logic [7:0]            rd_beat_q, rd_beat_d;

   logic [CNT_WIDTH-1:0]  wr_cnt_q, wr_cnt_d;
   logic [CNT_WIDTH-1:0]  rd_cnt_q, rd_cnt_d;
   logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
   logic                  pulse_q, pulse_d;

   logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic unused_inputs;

   assign unused_inputs = ^{SLAVE_WR_ADDR_BURST, SLAVE_WR_DATA, SLAVE_WR_STRB, SLAVE_RD_ADDR_BURST};

   assign aw_hs = aw_ready_q & SLAVE_WR_ADDR_VALID;
   assign w_hs  = w_ready_q  & SLAVE_WR_DATA_VALID;
   assign b_hs  = b_valid_q  & SLAVE_WR_BACK_READY;
   assign ar_hs = ar_ready_q & SLAVE_RD_ADDR_VALID;
   assign r_hs  = r_valid_q  & SLAVE_RD_DATA_READY;

   always_comb begin
      wr_state_d = wr_state_q;
      aw_ready_d = aw_ready_q;
      w_ready_d  = w_ready_q;
      b_valid_d  = b_valid_q;
      b_resp_d   = b_resp_q;
      b_id_d     = b_id_q;
      wr_id_d    = wr_id_q;
      wr_len_d   = wr_len_q;
      wr_beat_d  = wr_beat_q;
      case (wr_state_q)
         W_IDLE: begin
            aw_ready_d = 1'b1;
            if (aw_hs) begin
               aw_ready_d = 1'b0;
               w_ready_d  = 1'b1;
               wr_id_d    = SLAVE_WR_ADDR_ID;
               wr_len_d   = SLAVE_WR_ADDR_LEN;
               wr_beat_d  = 8'd0;
               wr_state_d = W_DATA;
            end
         end
         W_DATA: begin
            // Beat count also terminates the burst so a master that never sends WLAST cannot hang us.
            if (w_hs) begin
               wr_beat_d = wr_beat_q + 8'd1;
               if (SLAVE_WR_DATA_LAST || (wr_beat_q == wr_len_q)) begin
                  w_ready_d  = 1'b0;
                  b_valid_d  = 1'b1;
                  b_resp_d   = RESP_CODE;
                  b_id_d     = wr_id_q;
                  wr_state_d = W_RESP;
               end
            end
         end
         W_RESP: begin
            if (b_hs) begin
               b_valid_d  = 1'b0;
               b_resp_d   = 2'b00;
               aw_ready_d = 1'b1;
               wr_state_d = W_IDLE;
            end
         end
         default: wr_state_d = W_IDLE;
      endcase
   end

   always_comb begin
      rd_state_d = rd_state_q;
      ar_ready_d = ar_ready_q;
      r_valid_d  = r_valid_q;
      r_last_d   = r_last_q;
      r_resp_d   = r_resp_q;
      r_data_d   = r_data_q;
      r_id_d     = r_id_q;
      rd_len_d   = rd_len_q;
      rd_beat_d  = rd_beat_q;
      case (rd_state_q)
         R_IDLE: begin
            ar_ready_d = 1'b1;
            if (ar_hs) begin
               ar_ready_d = 1'b0;
               r_valid_d  = 1'b1;
               r_last_d   = (SLAVE_RD_ADDR_LEN == 8'd0);
               r_resp_d   = RESP_CODE;
               r_data_d   = RD_FILL_DATA;
               r_id_d     = SLAVE_RD_ADDR_ID;
               rd_len_d   = SLAVE_RD_ADDR_LEN;
               rd_beat_d  = 8'd0;
               rd_state_d = R_DATA;
            end
         end
         R_DATA: begin
            if (r_hs) begin
               if (r_last_q) begin
                  r_valid_d  = 1'b0;
                  r_last_d   = 1'b0;
                  r_resp_d   = 2'b00;
                  r_data_d   = '0;
                  ar_ready_d = 1'b1;
                  rd_state_d = R_IDLE;
               end else begin
                  rd_beat_d = rd_beat_q + 8'd1;
                  r_last_d  = ((rd_beat_q + 8'd1) == rd_len_q);
               end
            end
         end
         default: rd_state_d = R_IDLE;
      endcase
   end

   always_comb begin
      wr_cnt_d    = wr_cnt_q;
      rd_cnt_d    = rd_cnt_q;
      last_addr_d = last_addr_q;
      pulse_d     = aw_hs | ar_hs;
      if (aw_hs && (wr_cnt_q != '1)) wr_cnt_d = wr_cnt_q + CNT_WIDTH'(1);
      if (ar_hs && (rd_cnt_q != '1)) rd_cnt_d = rd_cnt_q + CNT_WIDTH'(1);
      // Write address takes priority when both channels handshake together.
      if (aw_hs)      last_addr_d = SLAVE_WR_ADDR;
      else if (ar_hs) last_addr_d = SLAVE_RD_ADDR;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_state_q  <= W_IDLE;
         aw_ready_q  <= 1'b0;
         w_ready_q   <= 1'b0;
         b_valid_q   <= 1'b0;
         b_resp_q    <= 2'b00;
         b_id_q      <= '0;
         wr_id_q     <= '0;
         wr_len_q    <= 8'd0;
         wr_beat_q   <= 8'd0;
         rd_state_q  <= R_IDLE;
         ar_ready_q  <= 1'b0;
         r_valid_q   <= 1'b0;
         r_last_q    <= 1'b0;
         r_resp_q    <= 2'b00;
         r_data_q    <= '0;
         r_id_q      <= '0;
         rd_len_q    <= 8'd0;
         rd_beat_q   <= 8'd0;
         wr_cnt_q    <= '0;
         rd_cnt_q    <= '0;
         last_addr_q <= '0;
         pulse_q     <= 1'b0;
      end else begin
         wr_state_q  <= wr_state_d;
         aw_ready_q  <= aw_ready_d;
         w_ready_q   <= w_ready_d;
         b_valid_q   <= b_valid_d;
         b_resp_q    <= b_resp_d;
         b_id_q      <= b_id_d;
         wr_id_q     <= wr_id_d;
         wr_len_q    <= wr_len_d;
         wr_beat_q   <= wr_beat_d;
         rd_state_q  <= rd_state_d;
         ar_ready_q  <= ar_ready_d;
         r_valid_q   <= r_valid_d;
         r_last_q    <= r_last_d;
         r_resp_q    <= r_resp_d;
         r_data_q    <= r_data_d;
         r_id_q      <= r_id_d;
         rd_len_q    <= rd_len_d;
         rd_beat_q   <= rd_beat_d;
         wr_cnt_q    <= wr_cnt_d;
         rd_cnt_q    <= rd_cnt_d;
         last_addr_q <= last_addr_d;
         pulse_q     <= pulse_d;
      end
   end

   assign SLAVE_CLK           = clk;
   assign SLAVE_RSTN          = ~rst;
   assign SLAVE_WR_ADDR_READY = aw_ready_q;
   assign SLAVE_WR_DATA_READY = w_ready_q;
   assign SLAVE_WR_BACK_ID    = b_id_q;
   assign SLAVE_WR_BACK_RESP  = b_resp_q;
   assign SLAVE_WR_BACK_VALID = b_valid_q;
   assign SLAVE_RD_ADDR_READY = ar_ready_q;
   assign SLAVE_RD_BACK_ID    = r_id_q;
   assign SLAVE_RD_DATA       = r_data_q;
   assign SLAVE_RD_DATA_RESP  = r_resp_q;
   assign SLAVE_RD_DATA_LAST  = r_last_q;
   assign SLAVE_RD_DATA_VALID = r_valid_q;
   assign err_wr_cnt          = wr_cnt_q;
   assign err_rd_cnt          = rd_cnt_q;
   assign last_err_addr       = last_addr_q;
   assign err_pulse           = pulse_q;

endmodule

// File: tb/tb_axi_slave_decerr.sv
// tb/tb_axi_slave_decerr.sv - randomized self-checking bench for axi_slave_decerr
module tb_axi_slave_decerr;

   localparam int         IDW = 4;
   localparam int         AW  = 32;
   localparam int         DW  = 32;
   localparam int         CW  = 2;
   localparam logic [1:0] RC  = 2'b11;
   localparam int         TMO = 600;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic slave_clk, slave_rstn;
   logic [IDW-1:0] aw_id;    logic [AW-1:0] aw_addr;  logic [7:0] aw_len;  logic [1:0] aw_burst;
   logic aw_valid, aw_ready;
   logic [DW-1:0] w_data;    logic [DW/8-1:0] w_strb; logic w_last, w_valid, w_ready;
   logic [IDW-1:0] b_id;     logic [1:0] b_resp;      logic b_valid, b_ready;
   logic [IDW-1:0] ar_id;    logic [AW-1:0] ar_addr;  logic [7:0] ar_len;  logic [1:0] ar_burst;
   logic ar_valid, ar_ready;
   logic [IDW-1:0] r_id;     logic [DW-1:0] r_data;   logic [1:0] r_resp;
   logic r_last, r_valid, r_ready;
   logic [CW-1:0] wr_cnt, rd_cnt;
   logic [AW-1:0] last_addr;
   logic pulse;

   int checks = 0;
   int passed = 0;
   int wr_n = 0;
   int rd_n = 0;

   axi_slave_decerr #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESP_CODE(RC),
                      .RD_FILL_DATA('0), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst), .SLAVE_CLK(slave_clk), .SLAVE_RSTN(slave_rstn),
      .SLAVE_WR_ADDR_ID(aw_id), .SLAVE_WR_ADDR(aw_addr), .SLAVE_WR_ADDR_LEN(aw_len),
      .SLAVE_WR_ADDR_BURST(aw_burst), .SLAVE_WR_ADDR_VALID(aw_valid), .SLAVE_WR_ADDR_READY(aw_ready),
      .SLAVE_WR_DATA(w_data), .SLAVE_WR_STRB(w_strb), .SLAVE_WR_DATA_LAST(w_last),
      .SLAVE_WR_DATA_VALID(w_valid), .SLAVE_WR_DATA_READY(w_ready),
      .SLAVE_WR_BACK_ID(b_id), .SLAVE_WR_BACK_RESP(b_resp), .SLAVE_WR_BACK_VALID(b_valid),
      .SLAVE_WR_BACK_READY(b_ready),
      .SLAVE_RD_ADDR_ID(ar_id), .SLAVE_RD_ADDR(ar_addr), .SLAVE_RD_ADDR_LEN(ar_len),
      .SLAVE_RD_ADDR_BURST(ar_burst), .SLAVE_RD_ADDR_VALID(ar_valid), .SLAVE_RD_ADDR_READY(ar_ready),
      .SLAVE_RD_BACK_ID(r_id), .SLAVE_RD_DATA(r_data), .SLAVE_RD_DATA_RESP(r_resp),
      .SLAVE_RD_DATA_LAST(r_last), .SLAVE_RD_DATA_VALID(r_valid), .SLAVE_RD_DATA_READY(r_ready),
      .err_wr_cnt(wr_cnt), .err_rd_cnt(rd_cnt), .last_err_addr(last_addr), .err_pulse(pulse)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [63:0] sat(input int n);
      int mx;
      mx = (1 << CW) - 1;
      return (n > mx) ? 64'(mx) : 64'(n);
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      aw_valid = 0; w_valid = 0; w_last = 0; b_ready = 0; ar_valid = 0; r_ready = 0;
      repeat (2) @(negedge clk);
      check("rst_aw_ready", aw_ready, 0);
      check("rst_ar_ready", ar_ready, 0);
      check("rst_w_ready", w_ready, 0);
      check("rst_b_valid", b_valid, 0);
      check("rst_r_valid", r_valid, 0);
      check("rst_r_last", r_last, 0);
      check("rst_wr_cnt", wr_cnt, 0);
      check("rst_rd_cnt", rd_cnt, 0);
      check("rst_last_addr", last_addr, 0);
      check("rst_pulse", pulse, 0);
      check("rst_rstn", slave_rstn, 0);
      rst = 1'b0;
      wr_n = 0;
      rd_n = 0;
      @(negedge clk);
      check("post_rst_aw_ready", aw_ready, 1);
      check("post_rst_ar_ready", ar_ready, 1);
      check("post_rst_rstn", slave_rstn, 1);
   endtask

   // Expected beat count: first WLAST or LEN+1 beats, whichever comes first.
   task automatic do_write(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                           input int wlast_at, input int bdelay, input bit chk_addr);
      int n, nbeats;
      nbeats = (wlast_at >= 0 && wlast_at <= int'(len)) ? wlast_at + 1 : int'(len) + 1;
      aw_id = id; aw_addr = addr; aw_len = len; aw_burst = 2'($urandom); aw_valid = 1;
      n = 0;
      while (aw_ready !== 1'b1 && n < TMO) begin @(negedge clk); n++; end
      if (n >= TMO) check("aw_ready_timeout", 0, 1);
      @(negedge clk);
      aw_valid = 0;
      wr_n++;
      check("aw_ready_drop", aw_ready, 0);
      check("w_ready_rise", w_ready, 1);
      check("pulse_aw", pulse, 1);
      check("err_wr_cnt", wr_cnt, sat(wr_n));
      if (chk_addr) check("last_addr_aw", last_addr, addr);
      for (int i = 0; i < nbeats; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         w_data = $urandom; w_strb = 4'($urandom); w_last = (i == wlast_at); w_valid = 1;
         n = 0;
         while (w_ready !== 1'b1 && n < TMO) begin @(negedge clk); n++; end
         if (n >= TMO) check("w_ready_timeout", 0, 1);
         @(negedge clk);
         w_valid = 0; w_last = 0;
         if (i < nbeats - 1) check("b_early", b_valid, 0);
      end
      check("w_ready_end", w_ready, 0);
      check("b_valid", b_valid, 1);
      check("b_id", b_id, id);
      check("b_resp", b_resp, RC);
      w_valid = 1;
      for (int k = 0; k < bdelay; k++) begin
         @(negedge clk);
         check("w_stall", w_ready, 0);
         check("b_hold", b_valid, 1);
      end
      w_valid = 0;
      b_ready = 1;
      @(negedge clk);
      b_ready = 0;
      check("b_valid_drop", b_valid, 0);
      check("aw_ready_back", aw_ready, 1);
   endtask

   task automatic do_read(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                          input bit pat_mode, input bit chk_addr);
      int n, i, step;
      int pat[5] = '{1, 0, 1, 1, 1};
      ar_id = id; ar_addr = addr; ar_len = len; ar_burst = 2'($urandom); ar_valid = 1;
      n = 0;
      while (ar_ready !== 1'b1 && n < TMO) begin @(negedge clk); n++; end
      if (n >= TMO) check("ar_ready_timeout", 0, 1);
      @(negedge clk);
      ar_valid = 0;
      rd_n++;
      check("ar_ready_drop", ar_ready, 0);
      check("pulse_ar", pulse, 1);
      check("err_rd_cnt", rd_cnt, sat(rd_n));
      if (chk_addr) check("last_addr_ar", last_addr, addr);
      i = 0; step = 0; n = 0;
      while (i <= int'(len) && n < 4 * TMO) begin
         check("r_valid", r_valid, 1);
         check("r_id", r_id, id);
         check("r_data", r_data, 0);
         check("r_resp", r_resp, RC);
         check("r_last", r_last, (i == int'(len)));
         r_ready = pat_mode ? ((step < 5) ? pat[step] != 0 : 1'b1) : 1'($urandom_range(0, 1));
         @(negedge clk);
         if (r_ready) i++;
         step++; n++;
      end
      if (n >= 4 * TMO) check("r_burst_timeout", 0, 1);
      r_ready = 0;
      check("r_valid_drop", r_valid, 0);
      check("r_last_drop", r_last, 0);
      check("ar_ready_back", ar_ready, 1);
   endtask

   initial begin
      aw_id = 0; aw_addr = 0; aw_len = 0; aw_burst = 0; aw_valid = 0;
      w_data = 0; w_strb = 0; w_last = 0; w_valid = 0; b_ready = 0;
      ar_id = 0; ar_addr = 0; ar_len = 0; ar_burst = 0; ar_valid = 0; r_ready = 0;
      do_reset();

      w_valid = 1;
      repeat (2) begin @(negedge clk); check("w_before_aw_stall", w_ready, 0); end
      w_valid = 0;

      do_write(4'h5, 32'h0000_1000, 8'd0, 0, 0, 1'b1);
      do_read(4'hA, 32'h4000_0000, 8'd3, 1'b1, 1'b1);
      do_write(4'h3, 32'h0000_2000, 8'd2, -1, 2, 1'b1);

      do_reset();
      fork
         do_write(4'h1, 32'h0000_0100, 8'd1, 1, 1, 1'b0);
         do_read(4'h2, 32'h0000_0200, 8'd2, 1'b0, 1'b0);
      join
      check("simul_last_addr", last_addr, 32'h100);
      check("simul_wr_cnt", wr_cnt, 1);
      check("simul_rd_cnt", rd_cnt, 1);

      ar_id = 4'h7; ar_addr = 32'h300; ar_len = 8'd7; ar_valid = 1;
      @(negedge clk);
      ar_valid = 0;
      r_ready = 1;
      repeat (2) @(negedge clk);
      check("midrst_r_valid", r_valid, 1);
      r_ready = 0;
      rst = 1;
      @(negedge clk);
      check("midrst_r_valid_drop", r_valid, 0);
      check("midrst_rd_cnt", rd_cnt, 0);
      check("midrst_wr_cnt", wr_cnt, 0);
      check("midrst_last_addr", last_addr, 0);
      rst = 0;
      wr_n = 0; rd_n = 0;
      @(negedge clk);
      check("midrst_ar_ready", ar_ready, 1);
      check("midrst_no_resp", r_valid, 0);
      do_read(4'h9, 32'h0000_0400, 8'd0, 1'b0, 1'b1);

      do_reset();
      for (int k = 0; k < 5; k++)
         do_write(4'($urandom), $urandom, 8'($urandom_range(0, 3)), -1, 0, 1'b1);
      check("sat_wr_cnt", wr_cnt, 3);
      check("sat_rd_cnt", rd_cnt, 0);

      do_reset();
      for (int k = 0; k < 30; k++) begin
         logic [7:0] len;
         if ($urandom_range(0, 1) == 1) begin
            int wl;
            len = (k == 3) ? 8'd255 : 8'($urandom_range(0, 7));
            wl = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, len);
            do_write(4'($urandom), $urandom, len, wl, $urandom_range(0, 3), 1'b1);
         end else begin
            len = (k == 4) ? 8'd255 : 8'($urandom_range(0, 9));
            do_read(4'($urandom), $urandom, len, 1'b0, 1'b1);
         end
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, checks);
      $fatal(1);
   end

endmodule
